ice40_master_spi_controller: RTL and testbench
==============================================

Name: ice40_master_spi_controller

Overview:
- Master-side sequencer for the iCE40UP5K SB_SPI hard IP, driving its system-bus register interface (strobe/rw/addr/data/ack).
- After reset it programs the IP as an SPI master, then sends one byte per tx_start request.
- It polls SPISR until TRDY is set, then writes the byte to SPITXDR.
- It sits between user logic and the SB_SPI primitive.

Parameters:
- SPI_CLK_DIVIDER, default 1: SPI baud divider. Bits [5:0] are written into SPIBR[5:0]; SPIBR[7:6] = 0. Legal range 0..63.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- tx_start, input, 1: request to send tx_data. Sampled only in IDLE.
- tx_data, input, 8: byte to transmit. Captured when tx_start is accepted.
- spi_data_out, input, 8: read data from SB_SPI (SBDATO). Valid when spi_ack = 1.
- spi_ack, input, 1: SB_SPI bus acknowledge (SBACKO).
- spi_rw, output, 1: 1 = register write, 0 = register read (SBRWI).
- spi_reg_addr, output, 8: register address (SBADRI).
- spi_strobe, output, 1: bus strobe (SBSTBI).
- spi_data_in, output, 8: write data (SBDATI). Drive 0x00 during reads.
- tx_busy, output, 1: 1 while initialising or transferring; 0 only in IDLE.

Behaviour:
- Register addresses: SPICR0=0x08, SPICR1=0x09, SPICR2=0x0A, SPIBR=0x0B, SPISR=0x0C, SPITXDR=0x0D, SPIRXDR=0x0E, SPICSR=0x0F.
- Reset values: spi_strobe=0, spi_rw=0, spi_reg_addr=0, spi_data_in=0, tx_busy=1. Latched byte = 0. State = INIT_CR0.
- Reset asserted mid-transaction: strobe drops on the next edge and the full init sequence restarts.
- Bus transaction rules:
  - Set rw, addr and data, then raise spi_strobe.
  - Hold strobe and all bus signals stable until spi_ack = 1 is sampled.
  - On that edge, deassert strobe. For reads, latch spi_data_out on the same edge.
  - Strobe stays low for at least 1 cycle between transactions.
  - Never raise strobe while spi_ack is still 1.
- Init sequence (writes in this exact order; tx_busy = 1 throughout):
  - INIT_CR0: write SPICR0 = 0x00.
  - INIT_CR1: write SPICR1 = 0x80 (SPE, enable core).
  - INIT_CR2: write SPICR2 = 0x81 (MSTR, LSBFE).
  - INIT_BR: write SPIBR = {2'b00, SPI_CLK_DIVIDER[5:0]}.
  - INIT_CSR: write SPICSR = 0x00.
  - Then go to IDLE.
- IDLE:
  - tx_busy = 0, strobe = 0.
  - tx_start = 1 on a clock edge: capture tx_data, set tx_busy = 1 on the same edge, go to POLL_SR.
- POLL_SR:
  - Read SPISR.
  - Read data bit 4 (TRDY) = 1: go to WRITE_TX.
  - TRDY = 0: issue another SPISR read. Poll without limit.
- WRITE_TX:
  - Write SPITXDR = latched byte, with tx_busy = 1.
  - On ack, return to IDLE. tx_busy falls the cycle after the ack is sampled.
- tx_start held high continuously: one byte is sent per pass through IDLE, with at least 1 IDLE cycle between bytes.
- tx_data changes after acceptance have no effect on the byte in flight.
- spi_strobe, spi_rw, spi_reg_addr, spi_data_in and tx_busy are all registered outputs.

Optional Feature:
- Macro: ICE40_SPI_DEBUG_EN.
- Defined: adds outputs b, g, r (1 bit each, registered, active-high, one-hot):
  - r = 1 during the init states and after reset.
  - g = 1 in IDLE.
  - b = 1 in POLL_SR / WRITE_TX.
- Undefined: these ports do not exist. Functional behaviour is identical either way.

Test Plan:
- Reset: hold reset 1 cycle -> tx_busy = 1, spi_strobe = 0. Release -> first strobe carries rw=1, addr=0x08, data=0x00.
- Init order (ack 2 cycles after each strobe), SPI_CLK_DIVIDER=1 -> writes in order:
  - 0x08/0x00
  - 0x09/0x80
  - 0x0A/0x81
  - 0x0B/0x01
  - 0x0F/0x00
  - then tx_busy = 0.
- Transmit: tx_data=0xAA, tx_start=1 -> SPISR read (rw=0, addr=0x0C). Ack data 0x10 -> write 0x0D/0xAA with tx_busy = 1, then tx_busy = 0.
- TRDY polling: first 3 SPISR reads return 0x00, 4th returns 0x10 -> exactly 4 reads of 0x0C, then one SPITXDR write.
- Handshake: delay ack by 5 cycles -> strobe, addr and data stay stable the whole time; strobe drops 1 cycle after ack; no new strobe while ack = 1.
- Reset mid-transfer: assert reset during POLL_SR -> strobe = 0 and tx_busy = 1 next cycle; after release the sequence restarts at the SPICR0 write.

Source files
------------

// File: rtl/ice40_master_spi_controller.sv
// Bus sequencer for the iCE40UP5K SB_SPI hard IP: configures master mode, then polls TRDY and writes one byte per request.
// Optional debug outputs b/g/r are enabled by defining ICE40_SPI_DEBUG_EN.
module ice40_master_spi_controller #(
  parameter int unsigned SPI_CLK_DIVIDER = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic [7:0] spi_data_out,
  input  logic       spi_ack,
  output logic       spi_rw,
  output logic [7:0] spi_reg_addr,
  output logic       spi_strobe,
  output logic [7:0] spi_data_in,
  output logic       tx_busy
`ifdef ICE40_SPI_DEBUG_EN
  ,
  output logic       b,
  output logic       g,
  output logic       r
`endif
);

  localparam logic [7:0] ADDR_SPICR0  = 8'h08;
  localparam logic [7:0] ADDR_SPICR1  = 8'h09;
  localparam logic [7:0] ADDR_SPICR2  = 8'h0A;
  localparam logic [7:0] ADDR_SPIBR   = 8'h0B;
  localparam logic [7:0] ADDR_SPISR   = 8'h0C;
  localparam logic [7:0] ADDR_SPITXDR = 8'h0D;
  localparam logic [7:0] ADDR_SPICSR  = 8'h0F;
  localparam logic [7:0] BR_VALUE     = {2'b00, 6'(SPI_CLK_DIVIDER)};

  typedef enum logic [2:0] {
    INIT_CR0, INIT_CR1, INIT_CR2, INIT_BR, INIT_CSR, IDLE, POLL_SR, WRITE_TX
  } state_t;

  state_t     r_state, w_state_nx, w_state_ack;
  logic       r_strobe, w_strobe_nx;
  logic       r_rw, w_rw_nx;
  logic [7:0] r_addr, w_addr_nx;
  logic [7:0] r_data, w_data_nx;
  logic       r_busy, w_busy_nx;
  logic [7:0] r_byte, w_byte_nx;
  logic       w_bus_req, w_req_rw, w_done_on_ack;
  logic [7:0] w_req_addr, w_req_data;

  always_comb begin
    w_state_nx    = r_state;
    w_strobe_nx   = r_strobe;
    w_rw_nx       = r_rw;
    w_addr_nx     = r_addr;
    w_data_nx     = r_data;
    w_busy_nx     = r_busy;
    w_byte_nx     = r_byte;
    w_bus_req     = 1'b0;
    w_req_rw      = 1'b0;
    w_req_addr    = '0;
    w_req_data    = '0;
    w_state_ack   = r_state;
    w_done_on_ack = 1'b0;

    unique case (r_state)
      INIT_CR0: begin
        w_bus_req = 1'b1; w_req_rw = 1'b1; w_req_addr = ADDR_SPICR0; w_req_data = 8'h00;
        w_state_ack = INIT_CR1;
      end
      INIT_CR1: begin
        w_bus_req = 1'b1; w_req_rw = 1'b1; w_req_addr = ADDR_SPICR1; w_req_data = 8'h80;
        w_state_ack = INIT_CR2;
      end
      INIT_CR2: begin
        w_bus_req = 1'b1; w_req_rw = 1'b1; w_req_addr = ADDR_SPICR2; w_req_data = 8'h81;
        w_state_ack = INIT_BR;
      end
      INIT_BR: begin
        w_bus_req = 1'b1; w_req_rw = 1'b1; w_req_addr = ADDR_SPIBR; w_req_data = BR_VALUE;
        w_state_ack = INIT_CSR;
      end
      INIT_CSR: begin
        w_bus_req = 1'b1; w_req_rw = 1'b1; w_req_addr = ADDR_SPICSR; w_req_data = 8'h00;
        w_state_ack = IDLE; w_done_on_ack = 1'b1;
      end
      IDLE: begin
        w_busy_nx = 1'b0;
        if (tx_start) begin
          w_byte_nx  = tx_data;
          w_busy_nx  = 1'b1;
          w_state_nx = POLL_SR;
        end
      end
      POLL_SR: begin
        w_bus_req = 1'b1; w_req_rw = 1'b0; w_req_addr = ADDR_SPISR; w_req_data = 8'h00;
        // TRDY is judged from the read data on the very edge the ack is sampled
        w_state_ack = spi_data_out[4] ? WRITE_TX : POLL_SR;
      end
      WRITE_TX: begin
        w_bus_req = 1'b1; w_req_rw = 1'b1; w_req_addr = ADDR_SPITXDR; w_req_data = r_byte;
        w_state_ack = IDLE; w_done_on_ack = 1'b1;
      end
      default: w_state_nx = INIT_CR0;
    endcase

    if (w_bus_req) begin
      if (r_strobe) begin
        if (spi_ack) begin
          w_strobe_nx = 1'b0;
          w_state_nx  = w_state_ack;
          if (w_done_on_ack) w_busy_nx = 1'b0;
        end
      end else if (!spi_ack) begin
        w_strobe_nx = 1'b1;
        w_rw_nx     = w_req_rw;
        w_addr_nx   = w_req_addr;
        w_data_nx   = w_req_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= INIT_CR0;
      r_strobe <= 1'b0;
      r_rw     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_busy   <= 1'b1;
      r_byte   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_strobe <= w_strobe_nx;
      r_rw     <= w_rw_nx;
      r_addr   <= w_addr_nx;
      r_data   <= w_data_nx;
      r_busy   <= w_busy_nx;
      r_byte   <= w_byte_nx;
    end
  end

  assign spi_strobe   = r_strobe;
  assign spi_rw       = r_rw;
  assign spi_reg_addr = r_addr;
  assign spi_data_in  = r_data;
  assign tx_busy      = r_busy;

`ifdef ICE40_SPI_DEBUG_EN
  logic r_dbg_b, r_dbg_g, r_dbg_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dbg_b <= 1'b0;
      r_dbg_g <= 1'b0;
      r_dbg_r <= 1'b1;
    end else begin
      r_dbg_b <= (w_state_nx == POLL_SR) || (w_state_nx == WRITE_TX);
      r_dbg_g <= (w_state_nx == IDLE);
      r_dbg_r <= (w_state_nx != IDLE) && (w_state_nx != POLL_SR) && (w_state_nx != WRITE_TX);
    end
  end

  assign b = r_dbg_b;
  assign g = r_dbg_g;
  assign r = r_dbg_r;
`endif

endmodule

// File: tb/tb_ice40_master_spi_controller.sv
// Directed bench: an SB_SPI bus responder logs every acknowledged transaction and flags handshake violations.
module tb_ice40_master_spi_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] spi_data_out = 8'h00;
  logic       spi_ack = 1'b0;
  logic       spi_rw;
  logic [7:0] spi_reg_addr;
  logic       spi_strobe;
  logic [7:0] spi_data_in;
  logic       tx_busy;
`ifdef ICE40_SPI_DEBUG_EN
  logic       dbg_b, dbg_g, dbg_r;
`endif

  ice40_master_spi_controller #(.SPI_CLK_DIVIDER(1)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .spi_data_out(spi_data_out), .spi_ack(spi_ack), .spi_rw(spi_rw),
    .spi_reg_addr(spi_reg_addr), .spi_strobe(spi_strobe),
    .spi_data_in(spi_data_in), .tx_busy(tx_busy)
`ifdef ICE40_SPI_DEBUG_EN
    , .b(dbg_b), .g(dbg_g), .r(dbg_r)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Responder state: {busy, rw, addr, data} per acknowledged transaction
  logic [17:0]  log_q[$];
  logic [7:0]   status_q[$];
  int unsigned  ack_delay = 2;
  int unsigned  ack_len = 1;
  int unsigned  wait_cnt = 0;
  int unsigned  hi_cnt = 0;
  int unsigned  stab_err = 0;
  int unsigned  rise_err = 0;
  int unsigned  drop_err = 0;
  logic         cap_rw;
  logic [7:0]   cap_addr, cap_data;

  initial begin
    forever begin
      @(negedge clk);
      if (hi_cnt > 0) begin
        hi_cnt--;
        if (hi_cnt == 0) begin
          spi_ack = 1'b0;
          spi_data_out = 8'h00;
        end
      end else if (spi_strobe) begin
        if (wait_cnt == 0) begin
          cap_rw = spi_rw; cap_addr = spi_reg_addr; cap_data = spi_data_in;
        end else if (spi_rw !== cap_rw || spi_reg_addr !== cap_addr || spi_data_in !== cap_data) begin
          stab_err++;
        end
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          log_q.push_back({tx_busy, spi_rw, spi_reg_addr, spi_data_in});
          if (!spi_rw) spi_data_out = (status_q.size() > 0) ? status_q.pop_front() : 8'h10;
          spi_ack = 1'b1;
          hi_cnt = ack_len;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    logic p, a;
    p = 1'b0;
    forever begin
      @(posedge clk);
      a = spi_ack;
      #1;
      if (!reset && spi_strobe && !p && a) rise_err++;
      if (!reset && p && a && spi_strobe) drop_err++;
      p = spi_strobe;
    end
  end

  task automatic wait_idle(input string nm, input int unsigned maxc);
    int unsigned c = 0;
    while (tx_busy !== 1'b0 && c < maxc) begin
      @(posedge clk); #1; c++;
    end
    chk(nm, {31'b0, tx_busy}, 32'd0);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data = d; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0; tx_data = ~d;
  endtask

  typedef struct {
    string       nm;
    logic        busy;
    logic        rw;
    logic [7:0]  addr;
    logic [7:0]  data;
  } txn_t;

  txn_t exp_tab[7];

  initial begin
    int unsigned writes;
    int unsigned idle_cyc;
    logic        bad_data;

    exp_tab[0] = '{"init_cr0", 1'b1, 1'b1, 8'h08, 8'h00};
    exp_tab[1] = '{"init_cr1", 1'b1, 1'b1, 8'h09, 8'h80};
    exp_tab[2] = '{"init_cr2", 1'b1, 1'b1, 8'h0A, 8'h81};
    exp_tab[3] = '{"init_br",  1'b1, 1'b1, 8'h0B, 8'h01};
    exp_tab[4] = '{"init_csr", 1'b1, 1'b1, 8'h0F, 8'h00};
    exp_tab[5] = '{"tx_poll",  1'b1, 1'b0, 8'h0C, 8'h00};
    exp_tab[6] = '{"tx_write", 1'b1, 1'b1, 8'h0D, 8'hAA};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   {31'b0, tx_busy}, 32'd1);
    chk("rst_strobe", {31'b0, spi_strobe}, 32'd0);
    chk("rst_rw",     {31'b0, spi_rw}, 32'd0);
    chk("rst_addr",   {24'b0, spi_reg_addr}, 32'd0);
    chk("rst_data",   {24'b0, spi_data_in}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    wait_idle("init_done", 200);
    chk("init_count", log_q.size(), 32'd5);

    send(8'hAA);
    #2;
    chk("tx_accept_busy", {31'b0, tx_busy}, 32'd1);
    wait_idle("tx_done", 200);
    chk("tx_count", log_q.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < log_q.size()) chk(exp_tab[i].nm, {14'b0, log_q[i]},
                                {14'b0, exp_tab[i].busy, exp_tab[i].rw, exp_tab[i].addr, exp_tab[i].data});
      else chk(exp_tab[i].nm, 32'hFFFF_FFFF, {14'b0, exp_tab[i].busy, exp_tab[i].rw, exp_tab[i].addr, exp_tab[i].data});
    end

    // TRDY polling: three not-ready reads before the write
    log_q.delete();
    status_q = '{8'h00, 8'hEF, 8'h00, 8'h10};
    send(8'h3C);
    wait_idle("poll_done", 400);
    chk("poll_count", log_q.size(), 32'd5);
    for (int i = 0; i < 4; i++)
      if (i < log_q.size()) chk("poll_read", {14'b0, log_q[i]}, {14'b0, 1'b1, 1'b0, 8'h0C, 8'h00});
    if (log_q.size() == 5) chk("poll_write", {14'b0, log_q[4]}, {14'b0, 1'b1, 1'b1, 8'h0D, 8'h3C});

    // Slow, long ack: signals must hold, strobe must not re-rise while ack is high
    log_q.delete();
    ack_delay = 6; ack_len = 3;
    send(8'h5A);
    wait_idle("hs_done", 400);
    chk("hs_count", log_q.size(), 32'd2);
    if (log_q.size() == 2) chk("hs_write", {14'b0, log_q[1]}, {14'b0, 1'b1, 1'b1, 8'h0D, 8'h5A});
    chk("hs_stable", stab_err, 32'd0);
    chk("hs_rise_ack", rise_err, 32'd0);
    chk("hs_drop", drop_err, 32'd0);

    // tx_start held high: repeated bytes, IDLE visited between them
    log_q.delete();
    ack_delay = 1; ack_len = 1;
    idle_cyc = 0;
    @(negedge clk);
    tx_data = 8'h77; tx_start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx_busy === 1'b0) idle_cyc++;
    end
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle("held_done", 200);
    writes = 0; bad_data = 1'b0;
    foreach (log_q[i]) if (log_q[i][16:8] == {1'b1, 8'h0D}) begin
      writes++;
      if (log_q[i][7:0] != 8'h77) bad_data = 1'b1;
    end
    chk("held_multi", {31'b0, writes >= 3}, 32'd1);
    chk("held_idle_gaps", {31'b0, idle_cyc + 1 >= writes}, 32'd1);
    chk("held_data", {31'b0, bad_data}, 32'd0);

    // Reset while polling: init must restart from SPICR0
    for (int i = 0; i < 40; i++) status_q.push_back(8'h00);
    send(8'hC3);
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_strobe", {31'b0, spi_strobe}, 32'd0);
    chk("mid_rst_busy",   {31'b0, tx_busy}, 32'd1);
    @(negedge clk);
    status_q.delete();
    log_q.delete();
    ack_delay = 2;
    @(negedge clk);
    reset = 1'b0;
    wait_idle("reinit_done", 200);
    chk("reinit_count", log_q.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < log_q.size()) chk({"re_", exp_tab[i].nm}, {14'b0, log_q[i]},
                                {14'b0, exp_tab[i].busy, exp_tab[i].rw, exp_tab[i].addr, exp_tab[i].data});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
